// File: rtl/decode_hazard_unit_pkg.sv
// Shared decode definitions: opcode values, IR field positions and per-opcode class tables.
package decode_hazard_unit_pkg;

  localparam logic [7:0] OpAdd  = 8'h01;
  localparam logic [7:0] OpSub  = 8'h02;
  localparam logic [7:0] OpAddi = 8'h03;
  localparam logic [7:0] OpLdi  = 8'h04;
  localparam logic [7:0] OpSt   = 8'h05;
  localparam logic [7:0] OpBeq  = 8'h06;
  localparam logic [7:0] OpJmp  = 8'h07;
  localparam logic [7:0] OpNop  = 8'hFF;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 24;
  localparam int unsigned DestMsb   = 23;
  localparam int unsigned DestLsb   = 20;
  localparam int unsigned Src1Msb   = 19;
  localparam int unsigned Src1Lsb   = 16;
  localparam int unsigned Src2Msb   = 11;
  localparam int unsigned Src2Lsb   = 8;
  localparam int unsigned ImmMsb    = 15;
  localparam int unsigned ImmLsb    = 0;

  typedef struct packed {
    logic writes_dest;
    logic uses_src1;
    logic uses_src2;
    logic is_branch;
  } op_class_t;

  typedef enum logic [0:0] {
    StIdle,
    StBrWait
  } br_state_e;

  // Indexed by opcode[2:0]; only opcodes 8'h00..8'h07 are defined, 8'h00 is a no-effect op.
  localparam op_class_t OpClassTable [8] = '{
    '{writes_dest: 1'b0, uses_src1: 1'b0, uses_src2: 1'b0, is_branch: 1'b0},  // 00
    '{writes_dest: 1'b1, uses_src1: 1'b1, uses_src2: 1'b1, is_branch: 1'b0},  // ADD
    '{writes_dest: 1'b1, uses_src1: 1'b1, uses_src2: 1'b1, is_branch: 1'b0},  // SUB
    '{writes_dest: 1'b1, uses_src1: 1'b1, uses_src2: 1'b0, is_branch: 1'b0},  // ADDI
    '{writes_dest: 1'b1, uses_src1: 1'b0, uses_src2: 1'b0, is_branch: 1'b0},  // LDI
    '{writes_dest: 1'b0, uses_src1: 1'b1, uses_src2: 1'b1, is_branch: 1'b0},  // ST
    '{writes_dest: 1'b0, uses_src1: 1'b1, uses_src2: 1'b0, is_branch: 1'b1},  // BEQ
    '{writes_dest: 1'b0, uses_src1: 1'b0, uses_src2: 1'b0, is_branch: 1'b1}   // JMP
  };

  function automatic op_class_t lookup_class(input logic [7:0] opcode);
    if (opcode[7:3] == 5'd0) begin
      return OpClassTable[opcode[2:0]];
    end
    return '0;
  endfunction

endpackage

// File: rtl/decode_hazard_unit_op_class.sv
// Combinational opcode-to-class decoder.
module decode_op_class
  import decode_hazard_unit_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  op_class
);

  assign op_class = lookup_class(opcode);

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode stage: register scoreboard for RAW/WAW stalls, branch-wait FSM and output latch.
module decode_hazard_unit
  import decode_hazard_unit_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned CNT_W    = 2
) (
  input  logic        I_CLOCK,
  input  logic        I_LOCK,
  input  logic [15:0] I_PC,
  input  logic [31:0] I_IR,
  input  logic        I_FE_Valid,
  input  logic        I_WB_Valid,
  input  logic [3:0]  I_WB_DestReg,
  input  logic        I_BranchAddrSelect,
  input  logic        I_GPUStallSignal,
  output logic        O_LOCK,
  output logic [15:0] O_PC,
  output logic [7:0]  O_Opcode,
  output logic [3:0]  O_DestReg,
  output logic [3:0]  O_Src1Reg,
  output logic [3:0]  O_Src2Reg,
  output logic [15:0] O_Imm,
  output logic        O_DE_Valid,
  output logic        O_DepStallSignal,
  output logic        O_BranchStallSignal
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [7:0]  opcode;
  logic [3:0]  dest, src1, src2;
  logic [15:0] imm;
  op_class_t   cls;

  assign opcode = I_IR[OpcodeMsb:OpcodeLsb];
  assign dest   = I_IR[DestMsb:DestLsb];
  assign src1   = I_IR[Src1Msb:Src1Lsb];
  assign src2   = I_IR[Src2Msb:Src2Lsb];
  assign imm    = I_IR[ImmMsb:ImmLsb];

  decode_op_class u_op_class (
    .opcode   (opcode),
    .op_class (cls)
  );

  logic [CNT_W-1:0] cnt_q   [NUM_REGS];
  logic [CNT_W-1:0] cnt_d   [NUM_REGS];
  logic [CNT_W-1:0] cnt_eff [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec, dec_vec;

  br_state_e   state_q;
  logic        lock_q;
  logic [15:0] pc_q, imm_q;
  logic [7:0]  opcode_q;
  logic [3:0]  dest_q, src1_q, src2_q;
  logic        valid_q;

  logic fe_live, src1_busy, src2_busy, dest_full, dep_hazard, issue;

  // A same-cycle writeback is folded in so a dependent instruction can issue right away.
  always_comb begin
    src1_busy = 1'b0;
    src2_busy = 1'b0;
    dest_full = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_eff[r] = cnt_q[r];
      if (I_WB_Valid && (I_WB_DestReg == 4'(r)) && (cnt_q[r] != '0)) begin
        cnt_eff[r] = cnt_q[r] - CNT_W'(1);
      end
      if ((src1 == 4'(r)) && (cnt_eff[r] != '0)) src1_busy = 1'b1;
      if ((src2 == 4'(r)) && (cnt_eff[r] != '0)) src2_busy = 1'b1;
      if ((dest == 4'(r)) && (cnt_eff[r] == CntMax)) dest_full = 1'b1;
    end
  end

  assign fe_live    = I_FE_Valid && (opcode != OpNop);
  // Words arriving during BR_WAIT are discarded unchecked.
  assign dep_hazard = fe_live && (state_q == StIdle) &&
                      ((cls.uses_src1 && src1_busy) || (cls.uses_src2 && src2_busy) ||
                       (cls.writes_dest && dest_full));
  assign issue      = I_LOCK && !I_GPUStallSignal && fe_live && (state_q == StIdle) &&
                      !dep_hazard;

  assign O_DepStallSignal    = I_LOCK && (I_GPUStallSignal || dep_hazard);
  assign O_BranchStallSignal = I_LOCK && ((state_q == StBrWait) || (issue && cls.is_branch));

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = issue && cls.writes_dest && (dest == 4'(r));
      dec_vec[r] = I_WB_Valid && (I_WB_DestReg == 4'(r));
      cnt_d[r]   = cnt_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(negedge I_CLOCK) begin
    lock_q <= I_LOCK;
    if (!I_LOCK) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      state_q  <= StIdle;
      pc_q     <= '0;
      opcode_q <= OpNop;
      dest_q   <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      imm_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      if (!I_GPUStallSignal) begin
        unique case (state_q)
          StIdle:   if (issue && cls.is_branch) state_q <= StBrWait;
          StBrWait: if (I_BranchAddrSelect) state_q <= StIdle;
          default:  state_q <= StIdle;
        endcase
        if (issue) begin
          pc_q     <= I_PC;
          opcode_q <= opcode;
          dest_q   <= dest;
          src1_q   <= src1;
          src2_q   <= src2;
          imm_q    <= imm;
          valid_q  <= 1'b1;
        end else begin
          valid_q  <= 1'b0;
        end
      end
    end
  end

  assign O_LOCK     = lock_q;
  assign O_PC       = pc_q;
  assign O_Opcode   = opcode_q;
  assign O_DestReg  = dest_q;
  assign O_Src1Reg  = src1_q;
  assign O_Src2Reg  = src2_q;
  assign O_Imm      = imm_q;
  assign O_DE_Valid = valid_q;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed bench for decode_hazard_unit: reset, RAW, WAW, branch wait, GPU stall, mid-run reset.
module tb_decode_hazard_unit;

  localparam logic [7:0] ADD = 8'h01;
  localparam logic [7:0] BEQ = 8'h06;

  logic        clk = 1'b0;
  logic        lock;
  logic [15:0] pc_in;
  logic [31:0] ir_in;
  logic        fe_valid, wb_valid, br_sel, gpu_stall;
  logic [3:0]  wb_reg;
  logic        o_lock, o_valid, dep_stall, br_stall;
  logic [15:0] o_pc, o_imm;
  logic [7:0]  o_opcode;
  logic [3:0]  o_dest, o_src1, o_src2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_hazard_unit dut (
    .I_CLOCK             (clk),
    .I_LOCK              (lock),
    .I_PC                (pc_in),
    .I_IR                (ir_in),
    .I_FE_Valid          (fe_valid),
    .I_WB_Valid          (wb_valid),
    .I_WB_DestReg        (wb_reg),
    .I_BranchAddrSelect  (br_sel),
    .I_GPUStallSignal    (gpu_stall),
    .O_LOCK              (o_lock),
    .O_PC                (o_pc),
    .O_Opcode            (o_opcode),
    .O_DestReg           (o_dest),
    .O_Src1Reg           (o_src1),
    .O_Src2Reg           (o_src2),
    .O_Imm               (o_imm),
    .O_DE_Valid          (o_valid),
    .O_DepStallSignal    (dep_stall),
    .O_BranchStallSignal (br_stall)
  );

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [3:0] d,
                                     input logic [3:0] s1, input logic [3:0] s2);
    return {op, d, s1, 4'h0, s2, 8'h00};
  endfunction

  task automatic drive(input logic v, input logic [15:0] pc, input logic [31:0] ir);
    fe_valid = v;
    pc_in    = pc;
    ir_in    = ir;
  endtask

  task automatic wb(input logic v, input logic [3:0] r);
    wb_valid = v;
    wb_reg   = r;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    lock = 1'b0; drive(1'b1, 16'h1234, mk(ADD, 4'd1, 4'd2, 4'd3)); wb(1'b0, 4'd0);
    br_sel = 1'b0; gpu_stall = 1'b0;
    tick(); tick(); settle();
    checks++; if (o_opcode !== 8'hFF) begin errors++; $display("FAIL rst_opcode: got %h want ff", o_opcode); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    checks++; if (o_pc !== 16'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", o_pc); end
    checks++; if ({o_dest, o_src1, o_src2, o_imm} !== 28'h0) begin errors++; $display("FAIL rst_fields: got %h want 0", {o_dest, o_src1, o_src2, o_imm}); end
    checks++; if ({dep_stall, br_stall} !== 2'b00) begin errors++; $display("FAIL rst_stalls: got %b want 00", {dep_stall, br_stall}); end
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL rst_olock: got %b want 0", o_lock); end
    lock = 1'b1; drive(1'b0, 16'h0, 32'h0);
    tick();
    checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL olock_release: got %b want 1", o_lock); end
  endtask

  task automatic test_raw();
    drive(1'b1, 16'h0004, mk(ADD, 4'd1, 4'd2, 4'd3)); settle();
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL raw_first_nostall: got %b want 0", dep_stall); end
    tick();
    checks++; if ({o_valid, o_opcode, o_dest, o_src1, o_src2} !== {1'b1, 8'h01, 4'd1, 4'd2, 4'd3}) begin errors++; $display("FAIL raw_first_issue: got %h want %h", {o_valid, o_opcode, o_dest, o_src1, o_src2}, {1'b1, 8'h01, 4'd1, 4'd2, 4'd3}); end
    checks++; if (o_pc !== 16'h0004 || o_imm !== 16'h0300) begin errors++; $display("FAIL raw_first_pcimm: got %h/%h want 0004/0300", o_pc, o_imm); end
    checks++; if (dut.cnt_q[1] !== 2'd1) begin errors++; $display("FAIL raw_cnt1_set: got %0d want 1", dut.cnt_q[1]); end
    drive(1'b1, 16'h0008, mk(ADD, 4'd2, 4'd1, 4'd0));
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: got %b want 1", dep_stall); end
      tick();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble: got %b want 0", o_valid); end
    end
    wb(1'b1, 4'd1); settle();
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL raw_wb_release: got %b want 0", dep_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h0008 || o_dest !== 4'd2) begin errors++; $display("FAIL raw_second_issue: got %b/%h/%0d want 1/0008/2", o_valid, o_pc, o_dest); end
    checks++; if (dut.cnt_q[1] !== 2'd0 || dut.cnt_q[2] !== 2'd1) begin errors++; $display("FAIL raw_cnts: got %0d/%0d want 0/1", dut.cnt_q[1], dut.cnt_q[2]); end
    drive(1'b0, 16'h0, 32'h0); wb(1'b1, 4'd2); tick(); wb(1'b0, 4'd0);
  endtask

  task automatic test_waw();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0020 + 16'(4 * i), mk(ADD, 4'd5, 4'd0, 4'd0)); tick();
    end
    checks++; if (dut.cnt_q[5] !== 2'd3) begin errors++; $display("FAIL waw_cnt3: got %0d want 3", dut.cnt_q[5]); end
    drive(1'b1, 16'h002C, mk(ADD, 4'd5, 4'd0, 4'd0)); settle();
    checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL waw_sat_stall: got %b want 1", dep_stall); end
    tick();
    checks++; if (o_valid !== 1'b0 || dut.cnt_q[5] !== 2'd3) begin errors++; $display("FAIL waw_sat_hold: got %b/%0d want 0/3", o_valid, dut.cnt_q[5]); end
    wb(1'b1, 4'd5); settle();
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL waw_wb_release: got %b want 0", dep_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h002C || dut.cnt_q[5] !== 2'd3) begin errors++; $display("FAIL waw_issue: got %b/%h/%0d want 1/002c/3", o_valid, o_pc, dut.cnt_q[5]); end
    drive(1'b0, 16'h0, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    checks++; if (dut.cnt_q[5] !== 2'd0) begin errors++; $display("FAIL waw_dec_floor: got %0d want 0", dut.cnt_q[5]); end
    wb(1'b0, 4'd0);
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 16'h0030, mk(ADD, 4'd3, 4'd0, 4'd0)); tick();
    drive(1'b1, 16'h0034, mk(ADD, 4'd3, 4'd0, 4'd0)); wb(1'b1, 4'd3); tick();
    checks++; if (o_valid !== 1'b1 || dut.cnt_q[3] !== 2'd1) begin errors++; $display("FAIL incdec_same: got %b/%0d want 1/1", o_valid, dut.cnt_q[3]); end
    drive(1'b0, 16'h0, 32'h0); tick(); wb(1'b0, 4'd0);
    checks++; if (dut.cnt_q[3] !== 2'd0) begin errors++; $display("FAIL incdec_drain: got %0d want 0", dut.cnt_q[3]); end
  endtask

  task automatic test_branch();
    drive(1'b1, 16'h0010, mk(BEQ, 4'd0, 4'd0, 4'd0)); br_sel = 1'b1; settle();
    checks++; if (br_stall !== 1'b1 || dep_stall !== 1'b0) begin errors++; $display("FAIL br_issue_stall: got %b/%b want 1/0", br_stall, dep_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h0010 || o_opcode !== 8'h06) begin errors++; $display("FAIL br_issue: got %b/%h/%h want 1/0010/06", o_valid, o_pc, o_opcode); end
    br_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'h0014 + 16'(4 * i), mk(ADD, 4'd4, 4'd0, 4'd0)); settle();
      checks++; if (br_stall !== 1'b1) begin errors++; $display("FAIL br_wait_stall: got %b want 1", br_stall); end
      tick();
      checks++; if (o_valid !== 1'b0 || dut.cnt_q[4] !== 2'd0) begin errors++; $display("FAIL br_discard: got %b/%0d want 0/0", o_valid, dut.cnt_q[4]); end
    end
    drive(1'b1, 16'h0040, mk(ADD, 4'd7, 4'd0, 4'd0)); br_sel = 1'b1; settle();
    checks++; if (br_stall !== 1'b1) begin errors++; $display("FAIL br_resolve_stall: got %b want 1", br_stall); end
    tick(); br_sel = 1'b0; settle();
    checks++; if (o_valid !== 1'b0 || br_stall !== 1'b0) begin errors++; $display("FAIL br_idle: got %b/%b want 0/0", o_valid, br_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h0040) begin errors++; $display("FAIL br_next_issue: got %b/%h want 1/0040", o_valid, o_pc); end
    drive(1'b0, 16'h0, 32'h0); wb(1'b1, 4'd7); tick(); wb(1'b0, 4'd0);
  endtask

  task automatic test_gpu_stall();
    drive(1'b1, 16'h0100, mk(ADD, 4'd1, 4'd0, 4'd0)); tick();
    drive(1'b1, 16'h0104, mk(ADD, 4'd2, 4'd1, 4'd0)); tick();
    checks++; if (o_valid !== 1'b0 || o_pc !== 16'h0100) begin errors++; $display("FAIL gpu_pre_bubble: got %b/%h want 0/0100", o_valid, o_pc); end
    gpu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb(i == 0, 4'd1); settle();
      checks++; if (dep_stall !== 1'b1) begin errors++; $display("FAIL gpu_dep_forced: got %b want 1", dep_stall); end
      tick();
      checks++; if (o_valid !== 1'b0 || o_pc !== 16'h0100 || o_dest !== 4'd1) begin errors++; $display("FAIL gpu_hold: got %b/%h/%0d want 0/0100/1", o_valid, o_pc, o_dest); end
    end
    checks++; if (dut.cnt_q[1] !== 2'd0) begin errors++; $display("FAIL gpu_wb_processed: got %0d want 0", dut.cnt_q[1]); end
    gpu_stall = 1'b0; settle();
    checks++; if (dep_stall !== 1'b0) begin errors++; $display("FAIL gpu_release: got %b want 0", dep_stall); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h0104 || dut.cnt_q[2] !== 2'd1) begin errors++; $display("FAIL gpu_issue: got %b/%h/%0d want 1/0104/1", o_valid, o_pc, dut.cnt_q[2]); end
    drive(1'b0, 16'h0, 32'h0); wb(1'b1, 4'd2); tick(); wb(1'b0, 4'd0);
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 16'h0300, mk(ADD, 4'd8, 4'd0, 4'd0)); tick();
    drive(1'b1, 16'h0304, mk(ADD, 4'd8, 4'd0, 4'd0)); tick();
    drive(1'b1, 16'h0308, mk(BEQ, 4'd0, 4'd0, 4'd0)); tick();
    checks++; if (dut.cnt_q[8] !== 2'd2 || br_stall !== 1'b1) begin errors++; $display("FAIL mid_setup: got %0d/%b want 2/1", dut.cnt_q[8], br_stall); end
    lock = 1'b0; wb(1'b1, 4'd8); drive(1'b1, 16'h030C, mk(ADD, 4'd8, 4'd8, 4'd0)); settle();
    checks++; if ({dep_stall, br_stall} !== 2'b00) begin errors++; $display("FAIL mid_rst_stalls: got %b want 00", {dep_stall, br_stall}); end
    tick();
    checks++; if (dut.cnt_q[8] !== 2'd0 || o_opcode !== 8'hFF || o_valid !== 1'b0 || o_lock !== 1'b0) begin errors++; $display("FAIL mid_rst_state: got %0d/%h/%b/%b want 0/ff/0/0", dut.cnt_q[8], o_opcode, o_valid, o_lock); end
    lock = 1'b1; wb(1'b0, 4'd0); drive(1'b1, 16'h0200, mk(ADD, 4'd9, 4'd8, 4'd0)); settle();
    checks++; if ({dep_stall, br_stall} !== 2'b00) begin errors++; $display("FAIL mid_after_stalls: got %b want 00", {dep_stall, br_stall}); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_pc !== 16'h0200 || o_lock !== 1'b1 || dut.cnt_q[9] !== 2'd1) begin errors++; $display("FAIL mid_after_issue: got %b/%h/%b/%0d want 1/0200/1/1", o_valid, o_pc, o_lock, dut.cnt_q[9]); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_same_cycle();
    test_branch();
    test_gpu_stall();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_hazard_unit.md
DECODE_HAZARD_UNIT -- requirements
Module: decode_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, the number of architectural registers tracked.
REQ-002 SHALL have parameter CNT_W, default 2, the width of each per-register in-flight write counter.
REQ-003 SHALL have port I_CLOCK, input, 1, the single clock; all state updates on negedge I_CLOCK.
REQ-004 SHALL have port I_LOCK, input, 1, synchronous active-low reset; 0 = reset, 1 = run.
REQ-005 SHALL have ports I_PC (input, 16, fetch-latch PC), I_IR (input, 32, fetch-latch instruction) and I_FE_Valid (input, 1, fetch-latch valid).
REQ-006 SHALL have ports I_WB_Valid (input, 1, writeback strobe) and I_WB_DestReg (input, 4, register being written back).
REQ-007 SHALL have port I_BranchAddrSelect, input, 1, branch resolved this cycle (from memory stage).
REQ-008 SHALL have port I_GPUStallSignal, input, 1, downstream stall: hold the output latch.
REQ-009 SHALL have port O_LOCK, output, 1, I_LOCK delayed one negedge.
REQ-010 SHALL have output ports O_PC (16), O_Opcode (8), O_DestReg (4), O_Src1Reg (4), O_Src2Reg (4), O_Imm (16) and O_DE_Valid (1), forming the decode output latch.
REQ-011 SHALL have output ports O_DepStallSignal (1) and O_BranchStallSignal (1), the stall requests to fetch.

Function
REQ-012 SHALL decode fields as opcode = IR[31:24], dest = IR[23:20], src1 = IR[19:16], src2 = IR[11:8], imm = IR[15:0].
REQ-013 SHALL treat opcode 8'hFF, or I_FE_Valid = 0, as a bubble: no hazard check, no scoreboard change, O_DE_Valid <= 0.
REQ-014 SHALL classify each opcode, via the package tables, as writes_dest, uses_src1, uses_src2 and is_branch.
REQ-015 SHALL keep one CNT_W-bit counter per register holding the number of issued, not-yet-written-back writes.
REQ-016 SHALL drive O_DepStallSignal combinationally to 1 when the latch holds a valid non-bubble instruction and either (a) a used source has a nonzero counter, or (b) writes_dest is set and the dest counter equals its maximum (3).
REQ-017 SHALL apply, in the dependency check, a same-cycle writeback that brings a counter to 0, so the instruction issues in that cycle.
REQ-018 SHALL, while O_DepStallSignal = 1, load a bubble into the output latch (O_DE_Valid <= 0) and leave the scoreboard unchanged.
REQ-019 SHALL, on issue (valid, no dep stall, I_GPUStallSignal = 0), register all fields, set O_DE_Valid <= 1 and increment the dest counter if writes_dest.
REQ-020 SHALL decrement the I_WB_DestReg counter on I_WB_Valid; decrementing a counter at 0 leaves it at 0.
REQ-021 SHALL leave the counter unchanged when an increment and a decrement hit the same register in the same cycle.
REQ-022 SHALL implement a branch FSM with states IDLE and BR_WAIT: IDLE -> BR_WAIT on issue of an is_branch instruction; BR_WAIT -> IDLE on I_BranchAddrSelect = 1.
REQ-023 SHALL drive O_BranchStallSignal = 1 combinationally in the cycle a branch issues, and for the whole time the FSM is in BR_WAIT.
REQ-024 SHALL, in BR_WAIT, discard latch contents as bubbles, with no issue and no scoreboard increment.
REQ-025 SHALL treat I_BranchAddrSelect = 1 in the same cycle a branch issues as not resolving that new branch.
REQ-026 SHALL, while I_GPUStallSignal = 1, hold every output-latch field and the FSM state, force O_DepStallSignal = 1 so fetch holds, and still process writebacks.

Reset
REQ-027 SHALL, while I_LOCK = 0 at negedge, clear all counters, set the FSM to IDLE, and set O_PC = 0, O_Opcode = 8'hFF, O_DestReg, O_Src1Reg, O_Src2Reg and O_Imm to 0, and O_DE_Valid = 0.
REQ-028 SHALL hold both stall outputs at 0 during reset.
REQ-029 SHALL, on reset mid-operation, discard in-flight branch and scoreboard state; a writeback in the reset cycle is ignored.

Structure
REQ-030 SHALL place the opcode constants, the NOP value 8'hFF, the field bit positions and the per-opcode class tables in the shared global definitions header.
REQ-031 SHALL contain one sub-module, decode_op_class: a combinational opcode-to-class decoder.
REQ-032 SHALL contain the scoreboard, FSM and output latch in decode_hazard_unit itself.

Verification
REQ-033 SHALL cover RAW: issue ADD R1 then ADD R2 using R1 -> second stalls (DepStall = 1, O_DE_Valid = 0) until I_WB_Valid with dest 1, then issues that same cycle.
REQ-034 SHALL cover WAW saturation: three writes to R5, no writeback -> fourth write to R5 stalls; one writeback of R5 -> it issues and the counter returns to 3.
REQ-035 SHALL cover a branch at PC 0x0010 -> BranchStall = 1 at issue and through BR_WAIT, two valid latch words discarded; I_BranchAddrSelect -> IDLE, next instruction issues.
REQ-036 SHALL cover an increment and decrement to R3 in the same cycle -> counter unchanged (1 stays 1).
REQ-037 SHALL cover I_GPUStallSignal for 3 cycles during RAW wait with a writeback -> outputs held, counter drops to 0, and the instruction issues the cycle after the stall ends.
REQ-038 SHALL cover I_LOCK = 0 during BR_WAIT with counters nonzero -> all counters 0, stalls 0, O_Opcode = 8'hFF, O_DE_Valid = 0.
